stim_check_seq: RTL and testbench

- Self-checking stimulus sequencer that sits directly upstream and downstream of a two-operand bitwise DUT (e.g. nand_b_b_b).
- Drives operands a/b exhaustively.
- Carries a golden expected value through a latency-matched delay line and compares it against the DUT result y.
- Reports pass/fail/done, an error count and the first failing step, replacing the hand-written per-step case checks in CI benches.

---
 rtl/stim_check_seq.sv | 204 ++++++++++++++++++++
 tb/tb_stim_check_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stim_check_seq.sv
// Exhaustive two-operand stimulus sequencer with a latency-matched golden compare of the DUT result.
// Build option STIM_CHECK_STOP_ON_FAIL_EN: end the run at the first mismatch.
module stim_check_seq #(
  parameter int WIDTH = 1,
  parameter int OP    = 0,
  parameter int LAT   = 0,
  parameter int HOLD  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [7:0]       err_count,
  output logic [15:0]      fail_step
);

  localparam int          KW     = 2 * WIDTH;
  localparam logic [KW:0] LAST_K = {1'b0, {KW{1'b1}}};
  localparam logic [KW:0] K_ONE  = {{KW{1'b0}}, 1'b1};
  localparam logic [7:0]  HOLD_V = 8'(HOLD);
  localparam logic [3:0]  LAT_V  = 4'(LAT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z);
    logic [WIDTH-1:0] r;
    case (OP)
      32'sd1:  r = x & z;
      32'sd2:  r = x | z;
      32'sd3:  r = x ^ z;
      32'sd4:  r = ~(x | z);
      32'sd5:  r = ~(x ^ z);
      default: r = ~(x & z);
    endcase
    return r;
  endfunction

  state_t           state_r;
  logic [7:0]       hold_r;
  logic [KW:0]      kcnt_r;
  logic [3:0]       dcnt_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic             busy_r, done_r, pass_r, fail_r;
  logic [7:0]       err_r;
  logic [15:0]      step_r;

  // Stage 0 is loaded together with a/b; stage LAT lines up with y.
  logic             dl_v_r [0:LAT];
  logic [WIDTH-1:0] dl_e_r [0:LAT];
  logic [KW-1:0]    dl_k_r [0:LAT];

  logic [WIDTH-1:0] exp_s;
  logic             mism_s;
  logic             fail_nx_s;

  assign a         = a_r;
  assign b         = b_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign fail      = fail_r;
  assign err_count = err_r;
  assign fail_step = step_r;

  // Golden value for the vector about to be driven, and the compare at the delay-line tail.
  always_comb begin
    exp_s  = golden(kcnt_r[WIDTH-1:0], kcnt_r[KW-1:WIDTH]);
    mism_s = 1'b0;
    if (dl_v_r[LAT]) begin
      // Written as equal/else so an unknown y lands on the mismatch branch.
      if (y == dl_e_r[LAT]) begin
        mism_s = 1'b0;
      end else begin
        mism_s = 1'b1;
      end
    end else begin
      mism_s = 1'b0;
    end
    fail_nx_s = fail_r | mism_s;
  end

  // Sequencer FSM, delay line and result bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      hold_r  <= 8'd0;
      kcnt_r  <= '0;
      dcnt_r  <= 4'd0;
      a_r     <= '0;
      b_r     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      fail_r  <= 1'b0;
      err_r   <= 8'd0;
      step_r  <= 16'd0;
      for (int i = 0; i <= LAT; i++) begin
        dl_v_r[i] <= 1'b0;
        dl_e_r[i] <= '0;
        dl_k_r[i] <= '0;
      end
    end else begin
      for (int i = LAT; i >= 1; i--) begin
        dl_v_r[i] <= dl_v_r[i-1];
        dl_e_r[i] <= dl_e_r[i-1];
        dl_k_r[i] <= dl_k_r[i-1];
      end
      dl_v_r[0] <= 1'b0;

      if (mism_s) begin
        if (err_r != 8'd255) begin
          err_r <= err_r + 8'd1;
        end
        if (!fail_r) begin
          fail_r <= 1'b1;
          step_r <= 16'(dl_k_r[LAT]);
        end
      end

      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            fail_r  <= 1'b0;
            err_r   <= 8'd0;
            step_r  <= 16'd0;
            kcnt_r  <= '0;
            hold_r  <= HOLD_V;
            state_r <= (HOLD_V == 8'd0) ? ST_RUN : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (hold_r <= 8'd1) begin
            hold_r  <= 8'd0;
            state_r <= ST_RUN;
          end else begin
            hold_r <= hold_r - 8'd1;
          end
        end
        ST_RUN: begin
          a_r       <= kcnt_r[WIDTH-1:0];
          b_r       <= kcnt_r[KW-1:WIDTH];
          dl_v_r[0] <= 1'b1;
          dl_e_r[0] <= exp_s;
          dl_k_r[0] <= kcnt_r[KW-1:0];
          kcnt_r    <= kcnt_r + K_ONE;
          if (kcnt_r == LAST_K) begin
            dcnt_r  <= 4'd0;
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The final drain cycle carries the compare of the last vector.
          if (dcnt_r == LAT_V) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= ~fail_nx_s;
          end else begin
            dcnt_r <= dcnt_r + 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase

`ifdef STIM_CHECK_STOP_ON_FAIL_EN
      if (mism_s && !fail_r) begin
        state_r <= ST_DONE;
        busy_r  <= 1'b0;
        done_r  <= 1'b1;
        pass_r  <= 1'b0;
        a_r     <= a_r;
        b_r     <= b_r;
        kcnt_r  <= kcnt_r;
        for (int i = 0; i <= LAT; i++) begin
          dl_v_r[i] <= 1'b0;
        end
      end
`else
      if (err_r == 8'd255) begin
        err_r <= 8'd255;
      end
`endif
    end
  end

endmodule

// File: tb/tb_stim_check_seq.sv
// Randomized bench for stim_check_seq: two configurations checked every cycle against a timing-formula model.
module tb_stim_check_seq;

  localparam int W0 = 1, OP0 = 0, L0 = 0, H0 = 2;
  localparam int W1 = 2, OP1 = 3, L1 = 2, H1 = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, start0, start1;
  logic [0:0]  a0, b0, y0;
  logic [1:0]  a1, b1, y1;
  logic        busy0, done0, pass0, fail0, busy1, done1, pass1, fail1;
  logic [7:0]  err0, err1;
  logic [15:0] step0, step1;
  logic [1:0]  p1 = 2'd0, p2 = 2'd0;

  int checks = 0, errors = 0;
  int mode[2], badk[2];
  int cw[2] = '{W0, W1};
  int cop[2] = '{OP0, OP1};
  int clat[2] = '{L0, L1};
  int chold[2] = '{H0, H1};

  // model state: time since accepted start, run end time, a/b before the run, per-vector mismatch
  bit run_on[2];
  int t_r[2], endt[2], prev_a[2], prev_b[2];
  bit mm[2][16];

  function automatic int gold(int op, int w, int x, int z);
    int r;
    case (op)
      1: r = x & z;
      2: r = x | z;
      3: r = x ^ z;
      4: r = ~(x | z);
      5: r = ~(x ^ z);
      default: r = ~(x & z);
    endcase
    return r & ((1 << w) - 1);
  endfunction

  // mode 0 correct, 1 stuck at all ones, 2 inverted, 3 one bad vector
  function automatic int dut_fn(int op, int w, int md, int bk, int x, int z);
    int g = gold(op, w, x, z);
    int m = (1 << w) - 1;
    case (md)
      1: return m;
      2: return (~g) & m;
      3: return ((x + (z << w)) == bk) ? (g ^ 1) : g;
      default: return g;
    endcase
  endfunction

  assign y0 = 1'(dut_fn(OP0, W0, mode[0], badk[0], int'(a0), int'(b0)));
  always @(posedge clock) begin
    p1 <= 2'(dut_fn(OP1, W1, mode[1], badk[1], int'(a1), int'(b1)));
    p2 <= p1;
  end
  assign y1 = p2;

  stim_check_seq #(.WIDTH(W0), .OP(OP0), .LAT(L0), .HOLD(H0)) u0 (
    .clock(clock), .reset(reset), .start(start0), .a(a0), .b(b0), .y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .fail(fail0),
    .err_count(err0), .fail_step(step0));

  stim_check_seq #(.WIDTH(W1), .OP(OP1), .LAT(L1), .HOLD(H1)) u1 (
    .clock(clock), .reset(reset), .start(start1), .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .fail(fail1),
    .err_count(err1), .fail_step(step1));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input int i, output int ea, output int eb, output int ebu,
                            output int edo, output int epa, output int efa,
                            output int eer, output int est);
    int n, h, l, w, vt, te, k;
    ea = prev_a[i]; eb = prev_b[i]; ebu = 0; edo = 0; epa = 0; efa = 0; eer = 0; est = 0;
    if (run_on[i]) begin
      w = cw[i]; h = chold[i]; l = clat[i]; n = 1 << (2 * w);
      vt = (t_r[i] < endt[i] - 1) ? t_r[i] : endt[i] - 1;
      if (vt >= h + 1) begin
        k = (vt - h - 1 < n - 1) ? vt - h - 1 : n - 1;
        ea = k & ((1 << w) - 1);
        eb = k >> w;
      end
      te = (t_r[i] < endt[i]) ? t_r[i] : endt[i];
      for (int j = 0; j < n; j++) begin
        if (mm[i][j] && (h + 2 + j + l <= te)) begin
          if (eer == 0) est = j;
          eer++;
        end
      end
      ebu = (t_r[i] < endt[i]) ? 1 : 0;
      edo = 1 - ebu;
      efa = (eer > 0) ? 1 : 0;
      epa = (edo == 1 && eer == 0) ? 1 : 0;
    end
  endtask

  task automatic model_step();
    int ea, eb, x1, x2, x3, x4, x5, x6, n, w, st;
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        run_on[i] = 1'b0; t_r[i] = 0; prev_a[i] = 0; prev_b[i] = 0;
      end else begin
        st = (i == 0) ? int'(start0) : int'(start1);
        if (st == 1 && !(run_on[i] && t_r[i] < endt[i])) begin
          expect_out(i, ea, eb, x1, x2, x3, x4, x5, x6);
          prev_a[i] = ea; prev_b[i] = eb;
          w = cw[i]; n = 1 << (2 * w);
          endt[i] = chold[i] + 1 + n + clat[i];
          for (int k = n - 1; k >= 0; k--) begin
            mm[i][k] = dut_fn(cop[i], w, mode[i], badk[i], k & ((1 << w) - 1), k >> w)
                       != gold(cop[i], w, k & ((1 << w) - 1), k >> w);
`ifdef STIM_CHECK_STOP_ON_FAIL_EN
            if (mm[i][k]) endt[i] = chold[i] + 2 + k + clat[i];
`endif
          end
          run_on[i] = 1'b1; t_r[i] = 0;
        end else if (run_on[i]) begin
          t_r[i]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    int ea, eb, ebu, edo, epa, efa, eer, est;
    for (int i = 0; i < 2; i++) begin
      expect_out(i, ea, eb, ebu, edo, epa, efa, eer, est);
      if (!reset) begin
        ea = 0; eb = 0; ebu = 0; edo = 0; epa = 0; efa = 0; eer = 0; est = 0;
      end
      if (i == 0) begin
        chk("u0.a", int'(a0), ea);        chk("u0.b", int'(b0), eb);
        chk("u0.busy", int'(busy0), ebu); chk("u0.done", int'(done0), edo);
        chk("u0.pass", int'(pass0), epa); chk("u0.fail", int'(fail0), efa);
        chk("u0.err", int'(err0), eer);   chk("u0.step", int'(step0), est);
      end else begin
        chk("u1.a", int'(a1), ea);        chk("u1.b", int'(b1), eb);
        chk("u1.busy", int'(busy1), ebu); chk("u1.done", int'(done1), edo);
        chk("u1.pass", int'(pass1), epa); chk("u1.fail", int'(fail1), efa);
        chk("u1.err", int'(err1), eer);   chk("u1.step", int'(step1), est);
      end
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clock);
      model_step();
      @(negedge clock);
      compare_all();
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  initial begin : driver
    int ncyc;
    reset = 1'b0; start0 = 1'b0; start1 = 1'b0;
    mode[0] = 0; badk[0] = 0; mode[1] = 2; badk[1] = 0;
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("lit.rst_busy0", int'(busy0), 0);
    chk("lit.rst_err1", int'(err1), 0);

    // correct NAND on u0, inverted XOR on u1, both started at E0
    start0 = 1'b1; start1 = 1'b1;
    step();
    start0 = 1'b0; start1 = 1'b0;
    repeat (3) step();
    chk("lit.e3_a0", int'(a0), 0);  chk("lit.e3_b0", int'(b0), 0);
    step();
    chk("lit.e4_a0", int'(a0), 1);  chk("lit.e4_b0", int'(b0), 0);
    step();
    chk("lit.e5_a0", int'(a0), 0);  chk("lit.e5_b0", int'(b0), 1);
    step();
    chk("lit.e6_a0", int'(a0), 1);  chk("lit.e6_b0", int'(b0), 1);
    chk("lit.e6_done0", int'(done0), 0);
    step();
    chk("lit.e7_done0", int'(done0), 1); chk("lit.e7_pass0", int'(pass0), 1);
    chk("lit.e7_err0", int'(err0), 0);
`ifdef STIM_CHECK_STOP_ON_FAIL_EN
    chk("lit.stop_done1", int'(done1), 1); chk("lit.stop_err1", int'(err1), 1);
    chk("lit.stop_a1", int'(a1), 2);       chk("lit.stop_b1", int'(b1), 0);
    repeat (15) step();
`else
    chk("lit.e7_done1", int'(done1), 0);
    repeat (14) step();
    chk("lit.e21_done1", int'(done1), 0);
    step();
    chk("lit.e22_done1", int'(done1), 1); chk("lit.e22_err1", int'(err1), 16);
    chk("lit.e22_step1", int'(step1), 0); chk("lit.e22_pass1", int'(pass1), 0);
`endif

    // restart u0 from DONE with y stuck at 1
    mode[0] = 1;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("lit.restart_done0", int'(done0), 0); chk("lit.restart_pass0", int'(pass0), 0);
    repeat (7) step();
    chk("lit.stuck_fail0", int'(fail0), 1); chk("lit.stuck_step0", int'(step0), 3);
    chk("lit.stuck_err0", int'(err0), 1);   chk("lit.stuck_pass0", int'(pass0), 0);

    // reset in the middle of a run, then a clean run
    mode[0] = 0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (5) step();
    chk("lit.k2_b0", int'(b0), 1);
    #1 reset = 1'b0;
    #1;
    chk("lit.rst_busy0", int'(busy0), 0); chk("lit.rst_b0", int'(b0), 0);
    chk("lit.rst_fail0", int'(fail0), 0); chk("lit.rst_done0", int'(done0), 0);
    step();
    reset = 1'b1;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (7) step();
    chk("lit.clean_done0", int'(done0), 1); chk("lit.clean_pass0", int'(pass0), 1);

    for (int it = 0; it < 50; it++) begin
      mode[0] = int'($urandom_range(0, 3)); badk[0] = int'($urandom_range(0, 3));
      mode[1] = int'($urandom_range(0, 3)); badk[1] = int'($urandom_range(0, 15));
      ncyc = int'($urandom_range(5, 40));
      for (int c = 0; c < ncyc; c++) begin
        start0 = ($urandom_range(0, 7) == 0);
        start1 = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 99) == 0) begin
          reset = 1'b0;
          step();
          step();
          reset = 1'b1;
        end
        step();
      end
      start0 = 1'b0; start1 = 1'b0;
      repeat (30) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
